// File: rtl/apb_master_bridge.sv
// APB requester: single-beat valid/ready commands become APB SETUP/ACCESS
// transfers, with one registered response per command and a wait-state timeout.
module apb_master_bridge #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              psel_nx, penable_nx, rsp_valid_nx, rsp_err_nx, load;
  logic [DATA_W-1:0] rsp_rdata_nx;

  assign cmd_ready = (state == IDLE) && rst_n;

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    psel_nx      = psel;
    penable_nx   = penable;
    rsp_valid_nx = 1'b0;
    rsp_err_nx   = rsp_err;
    rsp_rdata_nx = rsp_rdata;
    load         = 1'b0;
    case (state)
      IDLE: begin
        psel_nx    = 1'b0;
        penable_nx = 1'b0;
        if (cmd_valid) begin
          load     = 1'b1;
          psel_nx  = 1'b1;
          state_nx = SETUP;
        end
      end
      SETUP: begin
        penable_nx = 1'b1;
        cnt_nx     = '0;
        state_nx   = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          psel_nx      = 1'b0;
          penable_nx   = 1'b0;
          rsp_valid_nx = 1'b1;
          rsp_err_nx   = 1'b0;
          rsp_rdata_nx = pwrite ? '0 : prdata;
          state_nx     = IDLE;
        end else if ((TIMEOUT != 0) && (cnt == CNT_MAX)) begin
          // TIMEOUT-th consecutive stalled ACCESS edge: abandon the transfer
          psel_nx      = 1'b0;
          penable_nx   = 1'b0;
          rsp_valid_nx = 1'b1;
          rsp_err_nx   = 1'b1;
          rsp_rdata_nx = '0;
          state_nx     = IDLE;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      psel      <= psel_nx;
      penable   <= penable_nx;
      rsp_valid <= rsp_valid_nx;
      rsp_rdata <= rsp_rdata_nx;
      rsp_err   <= rsp_err_nx;
      if (load) begin
        paddr  <= cmd_addr;
        pwrite <= cmd_write;
        pwdata <= cmd_wdata;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: a table of single transfers against a
// small memory completer, plus timeout, back-to-back and mid-transfer reset.
module tb_apb_master_bridge;

  logic        pclk = 1'b0;
  logic        rst_n, cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata, rsp_rdata, paddr, pwdata, prdata;
  logic        rsp_valid, rsp_err, psel, penable, pwrite, pready;

  int unsigned passed = 0;
  int unsigned total  = 0;

  logic [31:0] mem [256];

  apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .pclk(pclk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pready(pready), .prdata(prdata)
  );

  always #5 pclk = ~pclk;

  // Completer memory: unwritten words read back as their own index.
  initial for (int i = 0; i < 256; i++) mem[i] = 32'(i);
  always_comb prdata = mem[paddr[7:0]];
  always @(posedge pclk)
    if (psel && penable && pready && pwrite) mem[paddr[7:0]] <= pwdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [6];

  // One transfer with a given number of pready-low ACCESS cycles.
  task automatic do_txn(input vec_t v);
    cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr; cmd_wdata = v.wdata;
    pready = 1'b0;
    chk("idle_cmd_ready", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    chk("setup_psel", psel, 1);
    chk("setup_penable", penable, 0);
    chk("setup_paddr", paddr, v.addr);
    chk("setup_pwrite", pwrite, v.write);
    chk("setup_busy", cmd_ready, 0);
    if (v.write) chk("setup_pwdata", pwdata, v.wdata);
    step();
    chk("access_penable", penable, 1);
    chk("access_psel", psel, 1);
    for (int w = 0; w < v.waits; w++) begin
      step();
      chk("wait_psel", psel, 1);
      chk("wait_penable", penable, 1);
      chk("wait_paddr", paddr, v.addr);
      chk("wait_pwrite", pwrite, v.write);
      chk("wait_no_rsp", rsp_valid, 0);
    end
    pready = 1'b1;
    step();
    pready = 1'b0;
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_rdata", rsp_rdata, v.exp_rdata);
    chk("rsp_err", rsp_err, 0);
    chk("done_psel", psel, 0);
    chk("done_cmd_ready", cmd_ready, 1);
    chk("done_paddr_hold", paddr, v.addr);
    step();
    chk("rsp_pulse_end", rsp_valid, 0);
    chk("rsp_rdata_hold", rsp_rdata, v.exp_rdata);
  endtask

  initial begin
    logic [31:0] exp_q [3];
    int          acc_cyc [3];
    int          n_acc, n_rsp, cyc;
    logic        acc;

    vecs[0] = '{1'b1, 32'h10, 32'hA5A5_0001, 0, 32'h0};
    vecs[1] = '{1'b0, 32'h05, 32'h0,         0, 32'h0000_0005};
    vecs[2] = '{1'b0, 32'h10, 32'h0,         0, 32'hA5A5_0001};
    vecs[3] = '{1'b0, 32'h10, 32'h0,         3, 32'hA5A5_0001};
    vecs[4] = '{1'b1, 32'h33, 32'hDEAD_BEEF, 2, 32'h0};
    vecs[5] = '{1'b0, 32'h33, 32'h0,         1, 32'hDEAD_BEEF};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; pready = 1'b0;
    step(); step();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_cmd_ready", cmd_ready, 1);
    step();

    foreach (vecs[i]) do_txn(vecs[i]);

    // Timeout: pready stuck low, abort on the 16th stalled ACCESS edge.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h44; pready = 1'b0;
    step();
    cmd_valid = 1'b0;
    step();
    chk("to_access", penable, 1);
    for (int k = 1; k < 16; k++) begin
      step();
      chk("to_held_psel", psel, 1);
      chk("to_no_rsp", rsp_valid, 0);
    end
    step();
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_rsp_err", rsp_err, 1);
    chk("to_rsp_rdata", rsp_rdata, 0);
    chk("to_psel", psel, 0);
    chk("to_penable", penable, 0);
    step();
    chk("to_pulse_end", rsp_valid, 0);
    chk("to_err_hold", rsp_err, 1);
    do_txn('{1'b0, 32'h05, 32'h0, 0, 32'h0000_0005});

    // Back-to-back with cmd_valid held high and a zero-wait completer.
    exp_q[0] = 32'hA5A5_0001; exp_q[1] = 32'h0; exp_q[2] = 32'h1234_5678;
    n_acc = 0; n_rsp = 0; cyc = 0;
    pready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h10; cmd_wdata = '0;
    while ((n_rsp < 3) && (cyc < 30)) begin
      acc = cmd_valid && cmd_ready;
      if (psel) chk("b2b_busy_not_ready", cmd_ready, 0);
      step();
      cyc++;
      if (rsp_valid) begin
        chk("b2b_rsp_rdata", rsp_rdata, exp_q[n_rsp]);
        chk("b2b_rsp_err", rsp_err, 0);
        n_rsp++;
      end
      if (acc) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
        case (n_acc)
          1: begin cmd_write = 1'b1; cmd_addr = 32'h20; cmd_wdata = 32'h1234_5678; end
          2: begin cmd_write = 1'b0; cmd_addr = 32'h20; cmd_wdata = '0; end
          default: cmd_valid = 1'b0;
        endcase
      end
    end
    chk("b2b_responses", n_rsp, 3);
    chk("b2b_accepts", n_acc, 3);
    if (n_acc == 3) begin
      chk("b2b_spacing1", acc_cyc[1] - acc_cyc[0], 3);
      chk("b2b_spacing2", acc_cyc[2] - acc_cyc[1], 3);
    end
    cmd_valid = 1'b0; pready = 1'b0;
    step();

    // Reset while in ACCESS: no response for the lost command.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h50; cmd_wdata = 32'h5555_AAAA;
    step();
    cmd_valid = 1'b0;
    step();
    chk("mid_access", penable, 1);
    rst_n = 1'b0;
    step();
    chk("mid_rst_psel", psel, 0);
    chk("mid_rst_penable", penable, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("mid_rst_no_rsp", rsp_valid, 0);
      chk("mid_rst_idle", psel, 0);
    end
    do_txn('{1'b0, 32'h50, 32'h0, 0, 32'h0000_0050});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("%0d/%0d checks passed", passed, total + 1);
    $fatal(1);
  end

endmodule
